// File: rtl/counter_rr_scheduler_pkg.sv
// counter_rr_scheduler_pkg: state encoding, default sizes and pointer-width helper
package counter_rr_scheduler_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) r = ((1 << r) < n) ? r + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/counter_rr_scheduler_if.sv
// counter_rr_scheduler_if: requester-side bundle between clients and the shared counter scheduler
interface counter_rr_scheduler_if
  import counter_rr_scheduler_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  logic [N-1:0]   REQ;
  logic [N*W-1:0] D;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic [W-1:0]   Q;
  logic           BUSY;
  modport master (output REQ, D, input GNT, DONE, Q, BUSY);
  modport slave  (input REQ, D, output GNT, DONE, Q, BUSY);
endinterface

// File: rtl/counter_rr_scheduler_counter_sload_ce.sv
// counter_sload_ce: W-bit up counter, priority reset > load > count enable
module counter_sload_ce #(
  parameter int W = 4
) (
  input  logic         C,
  input  logic         R,
  input  logic         LOAD,
  input  logic         CE,
  input  logic [W-1:0] DIN,
  output logic [W-1:0] Q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = LOAD ? DIN : CE ? q_q + 1'b1 : q_q;
  always_ff @(posedge C) begin
    if (R) q_q <= '0;
    else q_q <= q_d;
  end
  assign Q = q_q;
endmodule

// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler: round-robin sharing of one loadable up counter among N requesters.
// Define COUNTER_RR_SCHEDULER_ABORT_EN to let a grantee cancel its run by dropping REQ.
module counter_rr_scheduler
  import counter_rr_scheduler_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic C,
  input  logic R,
  counter_rr_scheduler_if.slave bus
);
  localparam int PW = clog2(N);
  localparam logic [PW:0] NN = (PW+1)'(N);
  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, sel, nxt;
  logic [PW:0]   cand;
  logic [N-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [W-1:0]  din, q;
  logic          load, ce, at_top, abort;
  // descending scan so the candidate closest to the pointer is written last and wins
  always_comb begin
    sel = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      cand = cand >= NN ? cand - NN : cand;
      if (bus.REQ[cand[PW-1:0]]) sel = cand[PW-1:0];
    end
  end
  always_comb begin
    din = '0;
    for (int i = 0; i < N; i++) if (sel == PW'(i)) din = bus.D[i*W +: W];
  end
  assign nxt = win_q == PW'(N - 1) ? '0 : win_q + 1'b1;
  assign at_top = &q;
`ifdef COUNTER_RR_SCHEDULER_ABORT_EN
  assign abort = !bus.REQ[win_q];
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    gnt_d = gnt_q;
    done_d = '0;
    load = 1'b0;
    ce = 1'b0;
    case (state_q)
      ST_IDLE: if (|bus.REQ) begin
        load = 1'b1;
        win_d = sel;
        gnt_d = N'(1) << sel;
        state_d = ST_RUN;
      end
      ST_RUN: if (abort) begin
        state_d = ST_IDLE;
        gnt_d = '0;
        ptr_d = nxt;
      end else if (at_top) begin
        state_d = ST_DONE;
        done_d = gnt_q;
      end else ce = 1'b1;
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d = '0;
        ptr_d = nxt;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      win_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
    end
  end
  counter_sload_ce #(.W(W)) u_cnt (
    .C   (C),
    .R   (R),
    .LOAD(load),
    .CE  (ce),
    .DIN (din),
    .Q   (q)
  );
  assign bus.GNT = gnt_q;
  assign bus.DONE = done_q;
  assign bus.Q = q;
  assign bus.BUSY = state_q != ST_IDLE;
endmodule

// File: tb/tb_counter_rr_scheduler.sv
// tb_counter_rr_scheduler: randomized scoreboard bench with a transaction-level reference model
module tb_counter_rr_scheduler;
  localparam int N = 4;
  localparam int W = 4;
  typedef struct {int w; int d; int g;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  counter_rr_scheduler_if #(.N(N), .W(W)) bus ();
  counter_rr_scheduler #(.N(N), .W(W)) dut (.C(clk), .R(rst), .bus(bus));
  always #5 clk = ~clk;
  int edge_n = 0;
  int rst_edge = -1;
  int n_cmp = 0;
  int n_bad = 0;
  int m_free = 0;
  int m_ptr = 0;
  ent_t exp_q[$];
  always @(posedge clk) edge_n <= edge_n + 1;
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask
  // The model decides a grant from the values that the next edge will sample.
  task automatic drive(input logic r, input logic [N-1:0] req, input logic [N*W-1:0] d);
    int ne, w, dv;
    @(negedge clk);
    rst = r;
    bus.REQ = req;
    bus.D = d;
    ne = edge_n + 1;
    if (r) begin
      exp_q.delete();
      m_free = ne + 1;
      m_ptr = 0;
      rst_edge = ne;
    end else if (ne >= m_free && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      dv = int'(d[w*W +: W]);
      exp_q.push_back('{w, dv, ne});
      m_free = ne + (2**W - dv) + 2;
      m_ptr = (w + 1) % N;
    end
  endtask
  initial begin
    ent_t cur;
    bit cur_v, started;
    int eg, ed, eq, eb, k, l, idle_q;
    cur_v = 0;
    started = 0;
    idle_q = 0;
    cur = '{0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (edge_n == rst_edge) begin
        started = 1;
        cur_v = 0;
        idle_q = 0;
      end
      if (started) begin
        if (exp_q.size() != 0 && exp_q[0].g == edge_n) begin
          cur = exp_q.pop_front();
          cur_v = 1;
        end
        eg = 0; ed = 0; eb = 0; eq = idle_q;
        if (cur_v) begin
          k = edge_n - cur.g;
          l = 2**W - cur.d;
          if (k < l) begin
            eg = 1 << cur.w; eq = cur.d + k; eb = 1;
          end else if (k == l) begin
            eg = 1 << cur.w; ed = eg; eq = 2**W - 1; eb = 1;
          end else begin
            eq = 2**W - 1; idle_q = eq;
          end
        end
        check("GNT", int'(bus.GNT), eg);
        check("DONE", int'(bus.DONE), ed);
        check("Q", int'(bus.Q), eq);
        check("BUSY", int'(bus.BUSY), eb);
      end
    end
  end
  initial begin
    logic [N*W-1:0] dv;
    bus.REQ = '0;
    bus.D = '0;
    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
    drive(1'b0, 4'b0001, 16'h000C);
    repeat (8) drive(1'b0, '0, '0);
    repeat (16) drive(1'b0, 4'b1111, 16'hFFFF);
    drive(1'b0, 4'b0011, 16'hFFFF);
    repeat (4) drive(1'b0, '0, 16'hFFFF);
    drive(1'b0, 4'b0010, 16'hFFFF);
    repeat (3) drive(1'b0, '0, 16'h1234);
    drive(1'b0, 4'b0011, 16'hFFFF);
    repeat (4) drive(1'b0, '0, '0);
    drive(1'b0, 4'b0100, 16'h0000);
    repeat (3) drive(1'b0, '0, 16'hFFFF);
    drive(1'b1, 4'b0100, '0);
    drive(1'b0, 4'b1010, 16'hF0F0);
    repeat (20) drive(1'b0, '0, '0);
    repeat (1500) begin
      for (int i = 0; i < N; i++) dv[i*W +: W] = ($urandom_range(0, 1) != 0) ? W'($urandom) : '1;
      drive($urandom_range(0, 59) == 0, N'($urandom), dv);
    end
    repeat (40) drive(1'b0, '0, '0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
